// File: rtl/cheri_tsmap_wr_engine.sv
// rtl/cheri_tsmap_wr_engine.sv - TSMAP range set/clear writer with read-modify-write for partial words
module cheri_tsmap_wr_engine #(
   parameter logic [31:0] HeapBase  = 32'h8000_0000,
   parameter int          TSMapSize = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_base_i,
   input  logic [31:0] req_top_i,
   input  logic        req_set_i,
   output logic        done_o,
   output logic        err_o,
   input  logic        tsmap_gnt_i,
   output logic        tsmap_cs_o,
   output logic        tsmap_we_o,
   output logic [15:0] tsmap_addr_o,
   output logic [31:0] tsmap_wdata_o,
   input  logic [31:0] tsmap_rdata_i
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SEL  = 3'd1;
   localparam logic [2:0] ST_RD   = 3'd2;
   localparam logic [2:0] ST_MRG  = 3'd3;
   localparam logic [2:0] ST_WR   = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   localparam logic [31:0] MapWords = 32'(TSMapSize);

   logic [2:0]  state;
   logic [15:0] word;
   logic [15:0] first_word;
   logic [15:0] last_word;
   logic [4:0]  first_bit;
   logic [4:0]  last_bit;
   logic        set_q;
   logic        err_q;
   logic [31:0] wdata_q;

   // Granule arithmetic on the incoming request (top is exclusive, rounded up to a granule)
   logic [31:0] top_up;
   logic [31:0] g0;
   logic [31:0] g1;
   logic [31:0] gl;
   logic        empty;
   logic        bad;

   assign top_up = (req_top_i + 32'd7) & ~32'd7;
   assign g0     = (req_base_i - HeapBase) >> 3;
   assign g1     = (top_up - HeapBase) >> 3;
   assign gl     = g1 - 32'd1;
   assign empty  = (g1 == g0);
   // An empty range never touches the map, so only a non-empty one is checked against its size
   assign bad    = (req_base_i < HeapBase) | (req_top_i < req_base_i) |
                   (!empty && ({5'd0, gl[31:5]} >= MapWords));

   // Bits of the current word covered by the range: trimmed only on the first and last words
   logic [4:0]  lo;
   logic [4:0]  hi;
   logic [31:0] mask;

   assign lo   = (word == first_word) ? first_bit : 5'd0;
   assign hi   = (word == last_word)  ? last_bit  : 5'd31;
   assign mask = (32'hFFFF_FFFF << lo) & (32'hFFFF_FFFF >> (5'd31 - hi));

   // Port outputs decode straight from state so a stalled access holds every field stable
   assign req_ready_o   = (state == ST_IDLE) & ~rst_i;
   assign tsmap_cs_o    = (state == ST_RD) | (state == ST_WR);
   assign tsmap_we_o    = (state == ST_WR);
   assign tsmap_addr_o  = tsmap_cs_o ? word : 16'd0;
   assign tsmap_wdata_o = tsmap_we_o ? wdata_q : 32'd0;
   assign done_o        = (state == ST_DONE);
   assign err_o         = done_o & err_q;

   // Range walker: accept, then per word choose blind write or read-merge-write
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         word       <= 16'd0;
         first_word <= 16'd0;
         last_word  <= 16'd0;
         first_bit  <= 5'd0;
         last_bit   <= 5'd0;
         set_q      <= 1'b0;
         err_q      <= 1'b0;
         wdata_q    <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  first_word <= g0[20:5];
                  first_bit  <= g0[4:0];
                  last_word  <= gl[20:5];
                  last_bit   <= gl[4:0];
                  word       <= g0[20:5];
                  set_q      <= req_set_i;
                  err_q      <= bad;
                  state      <= (bad | empty) ? ST_DONE : ST_SEL;
               end
            end
            ST_SEL: begin
               if (mask == 32'hFFFF_FFFF) begin
                  wdata_q <= set_q ? 32'hFFFF_FFFF : 32'd0;
                  state   <= ST_WR;
               end else begin
                  state   <= ST_RD;
               end
            end
            ST_RD: begin
               if (tsmap_gnt_i) state <= ST_MRG;
            end
            ST_MRG: begin
               wdata_q <= set_q ? (tsmap_rdata_i | mask) : (tsmap_rdata_i & ~mask);
               state   <= ST_WR;
            end
            ST_WR: begin
               if (tsmap_gnt_i) begin
                  if (word == last_word) begin
                     state <= ST_DONE;
                  end else begin
                     word  <= word + 16'd1;
                     state <= ST_SEL;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cheri_tsmap_wr_engine.sv
// tb/tb_cheri_tsmap_wr_engine.sv - scoreboard bench for the TSMAP range writer
module tb_cheri_tsmap_wr_engine;

   localparam logic [31:0] HB  = 32'h8000_0000;
   localparam longint      HBL = 64'h8000_0000;
   localparam int          NW  = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_base;
   logic [31:0] req_top;
   logic        req_set;
   logic        done;
   logic        err;
   logic        tsmap_gnt;
   logic        cs;
   logic        we;
   logic [15:0] addr;
   logic [31:0] wdata;
   logic [31:0] tsmap_rdata;

   always #5 clk = ~clk;

   cheri_tsmap_wr_engine #(.HeapBase(HB), .TSMapSize(NW)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_base_i(req_base), .req_top_i(req_top), .req_set_i(req_set),
      .done_o(done), .err_o(err),
      .tsmap_gnt_i(tsmap_gnt), .tsmap_cs_o(cs), .tsmap_we_o(we),
      .tsmap_addr_o(addr), .tsmap_wdata_o(wdata), .tsmap_rdata_i(tsmap_rdata)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cnt = 0;

   logic [31:0] ref_mem [NW];
   logic [47:0] exp_wr [$];
   logic [15:0] exp_rd [$];
   logic        exp_err [$];
   int          exp_cyc [$];

   logic        pl_en = 1'b0;
   logic [15:0] pl_addr = 16'd0;
   logic [31:0] pl_data = 32'd0;
   int          stall_cnt;
   bit          stall_rd, stall_wr, rand_gnt;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_val(input int i);
      return (32'(i) * 32'h9E37_79B9) ^ 32'hA5C3_0F1E;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic flag(input string name, input logic [63:0] got);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected nothing", name, got);
   endtask

   // TSMAP memory seen by the engine: registered read data, writes on grant
   initial begin
      logic [31:0] mem [NW];
      for (int i = 0; i < NW; i++) mem[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (pl_en) mem[pl_addr[9:0]] = pl_data;
         if (cs && tsmap_gnt) begin
            if (we) mem[addr[9:0]] = wdata;
            else    tsmap_rdata <= mem[addr[9:0]];
         end
      end
   end

   // Monitor: pops expected accesses and completions, checks hold-while-ungranted
   initial begin
      logic        pend, pwe, ee;
      logic [15:0] paddr, er;
      logic [31:0] pwd;
      logic [47:0] ew;
      int          ec;
      pend = 1'b0; pwe = 1'b0; paddr = 16'd0; pwd = 32'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               chk("hold_cs", cs, 1);
               chk("hold_we", we, pwe);
               chk("hold_addr", addr, paddr);
               chk("hold_wdata", wdata, pwd);
            end
            if (cs && tsmap_gnt) begin
               if (we) begin
                  if (exp_wr.size() == 0) flag("unexpected_write", {addr, wdata});
                  else begin
                     ew = exp_wr.pop_front();
                     chk("wr_addr", addr, ew[47:32]);
                     chk("wr_data", wdata, ew[31:0]);
                  end
               end else begin
                  if (exp_rd.size() == 0) flag("unexpected_read", addr);
                  else begin
                     er = exp_rd.pop_front();
                     chk("rd_addr", addr, er);
                  end
               end
            end
            if (done) begin
               if (exp_err.size() == 0) flag("unexpected_done", err);
               else begin
                  ee = exp_err.pop_front();
                  ec = exp_cyc.pop_front();
                  chk("done_err", err, ee);
                  if (ec >= 0) chk("done_cycle", cyc, ec);
                  chk("writes_left", exp_wr.size(), 0);
                  chk("reads_left", exp_rd.size(), 0);
               end
               done_cnt++;
            end
            pend = cs && !tsmap_gnt; pwe = we; paddr = addr; pwd = wdata;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
         tsmap_gnt = 1'b0;
         stall_cnt--;
      end else begin
         tsmap_gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (stall_rd && cs && !we) begin stall_rd = 0; tsmap_gnt = 1'b0; stall_cnt = 2; end
      if (stall_wr && cs && we)  begin stall_wr = 0; tsmap_gnt = 1'b0; stall_cnt = 2; end
   endtask

   task automatic preload(input int a, input logic [31:0] d);
      pl_addr = 16'(a); pl_data = d; pl_en = 1'b1;
      tick();
      pl_en = 1'b0;
      ref_mem[a] = d;
   endtask

   // Reference: walk every granule of the range, group by word; latency assumes immediate grants
   task automatic model(input logic [31:0] b, input logic [31:0] t, input logic s,
                        output logic e, output int lat);
      longint bl, tl, tu, g0, g1, g;
      logic [31:0] v;
      int n;
      bl = longint'(b); tl = longint'(t);
      tu = ((tl + 7) / 8) * 8;
      e = (bl < HBL) || (tl < bl);
      lat = 1;
      if (!e) begin
         g0 = (bl - HBL) / 8;
         g1 = (tu - HBL) / 8;
         if (g1 > g0 && (g1 - 1) / 32 >= NW) e = 1'b1;
         if (!e && g1 > g0) begin
            for (int w = int'(g0 / 32); w <= int'((g1 - 1) / 32); w++) begin
               v = ref_mem[w];
               n = 0;
               for (int k = 0; k < 32; k++) begin
                  g = longint'(w) * 32 + k;
                  if (g >= g0 && g < g1) begin
                     n++;
                     v[k] = s;
                  end
               end
               if (n < 32) exp_rd.push_back(16'(w));
               exp_wr.push_back({16'(w), v});
               ref_mem[w] = v;
               lat += (n < 32) ? 4 : 2;
            end
         end
      end
   endtask

   task automatic issue(input logic [31:0] b, input logic [31:0] t, input logic s, input int extra);
      logic e;
      int lat, start;
      chk("ready_before_req", req_ready, 1);
      model(b, t, s, e, lat);
      exp_err.push_back(e);
      exp_cyc.push_back(extra < 0 ? -1 : cyc + lat + extra);
      req_base = b; req_top = t; req_set = s; req_valid = 1'b1;
      start = done_cnt;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 400 && done_cnt == start; i++) tick();
      chk("done_seen", done_cnt != start, 1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_cs"}, cs, 0);
      chk({tag, "_we"}, we, 0);
      chk({tag, "_addr"}, addr, 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_ready"}, req_ready, 1);
   endtask

   initial begin
      logic        e;
      int          lat, r;
      logic [31:0] b, t, old5, old6;
      rst = 1'b1; req_valid = 1'b0; req_base = 32'd0; req_top = 32'd0; req_set = 1'b0;
      tsmap_gnt = 1'b1; stall_cnt = 0; stall_rd = 0; stall_wr = 0; rand_gnt = 0;
      for (int i = 0; i < NW; i++) ref_mem[i] = init_val(i);
      repeat (3) tick();
      chk("ready_in_reset", req_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      chk_idle("reset");
      tick();

      issue(HB, HB + 32'h100, 1'b1, 0);
      preload(0, 32'h8000_0000);
      issue(HB + 32'h8, HB + 32'h18, 1'b1, 0);
      preload(0, 32'hFFFF_FFFF);
      preload(1, 32'hFFFF_FFFF);
      issue(HB + 32'hF8, HB + 32'h108, 1'b0, 0);
      issue(32'h7FFF_FFF8, HB + 32'h10, 1'b1, 0);
      issue(HB, 32'h8004_0008, 1'b1, 0);
      issue(HB + 32'h100, HB + 32'h80, 1'b1, 0);
      issue(HB + 32'h100, HB + 32'h100, 1'b1, 0);
      issue(32'h8003_FFF8, 32'h8004_0000, 1'b1, 0);

      stall_rd = 1; stall_wr = 1;
      issue(HB + 32'h208, HB + 32'h230, 1'b1, 6);

      old5 = ref_mem[5]; old6 = ref_mem[6];
      model(HB + 32'h400, HB + 32'h700, 1'b1, e, lat);
      exp_err.push_back(e); exp_cyc.push_back(-1);
      req_base = HB + 32'h400; req_top = HB + 32'h700; req_set = 1'b1; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 20 && !(cs && we && addr == 16'd5); i++) tick();
      chk("reached_wr_word1", cs && we && addr == 16'd5, 1);
      tsmap_gnt = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; tsmap_gnt = 1'b1;
      exp_wr.delete(); exp_rd.delete(); exp_err.delete(); exp_cyc.delete();
      ref_mem[5] = old5; ref_mem[6] = old6;
      @(negedge clk);
      chk_idle("midreset");
      repeat (4) tick();
      issue(HB + 32'h508, HB + 32'h540, 1'b0, 0);

      rand_gnt = 1;
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         b = HB + $urandom_range(0, 32'h3000);
         t = b + $urandom_range(0, 32'h600);
         if (r == 0)      b = HB - $urandom_range(1, 64);
         else if (r == 1) t = b - $urandom_range(1, 64);
         else if (r == 2) t = b;
         issue(b, t, 1'($urandom_range(0, 1)), -1);
      end
      rand_gnt = 0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
